mips_multicycle_core: RTL and testbench

MIPS_MULTICYCLE_CORE -- requirements
Module: mips_multicycle_core

---
 rtl/mips_multicycle_core_pkg.sv | 53 +++++
 rtl/mips_multicycle_core_if.sv | 21 ++
 rtl/mips_multicycle_core_regfile.sv | 42 ++++
 rtl/mips_multicycle_core.sv | 180 ++++++++++++++++++
 tb/tb_mips_multicycle_core.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_multicycle_core_pkg.sv
// Shared constants for the multi-cycle MIPS core: opcodes, funct codes,
// ALU operation encoding, FSM states and small decode helpers.
package mips_multicycle_core_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT
  } alu_op_t;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_TRAP
  } state_t;

  function automatic alu_op_t funct_to_alu(logic [5:0] fn);
    case (fn)
      FN_SUB:  return ALU_SUB;
      FN_AND:  return ALU_AND;
      FN_OR:   return ALU_OR;
      FN_SLT:  return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

  function automatic logic is_legal(logic [5:0] op, logic [5:0] fn);
    case (op)
      OP_RTYPE: return fn inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
      OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J: return 1'b1;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mips_multicycle_core_if.sv
// Shared single-port memory bus between the core (master) and memory (slave).
interface mips_multicycle_core_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_read;
  logic              mem_write;
  logic [31:0]       mem_rdata;
  logic              mem_ready;

  modport master (
    output mem_addr, mem_wdata, mem_read, mem_write,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_read, mem_write,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/mips_multicycle_core_regfile.sv
// 32x32 register file: two asynchronous read ports, one synchronous write
// port, register 0 always reads zero and ignores writes.
module regfile_2r1w (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  raddr_a,
  output logic [31:0] rdata_a,
  input  logic [4:0]  raddr_b,
  output logic [31:0] rdata_b,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata
);

  logic [31:0] regs [32];
  logic [31:0] wsel;

  // One-hot write select; entry 0 is never selected.
  generate
    for (genvar gi = 0; gi < 32; gi++) begin : g_wsel
      assign wsel[gi] = we && (waddr == 5'(gi)) && (gi != 0);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= 32'd0;
      end
    end else begin
      for (int i = 0; i < 32; i++) begin
        if (wsel[i]) begin
          regs[i] <= wdata;
        end
      end
    end
  end

  assign rdata_a = (raddr_a == 5'd0) ? 32'd0 : regs[raddr_a];
  assign rdata_b = (raddr_b == 5'd0) ? 32'd0 : regs[raddr_b];

endmodule

// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS core sharing one memory port for fetch and data access.
// Holds the control FSM, the ALU and the datapath registers.
module mips_multicycle_core
  import mips_multicycle_core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  mips_multicycle_core_if.master bus,
  output logic                   retire,
  output logic                   trap,
  output logic [31:0]            pc
);

  state_t      state_reg;
  logic [31:0] pc_reg;
  logic [31:0] ir_reg;
  logic [31:0] a_reg;
  logic [31:0] b_reg;
  logic [31:0] mdr_reg;
  logic [31:0] alu_out_reg;
  logic [31:0] target_reg;

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [31:0] imm_sext;

  assign opcode   = ir_reg[31:26];
  assign rs       = ir_reg[25:21];
  assign rt       = ir_reg[20:16];
  assign rd       = ir_reg[15:11];
  assign funct    = ir_reg[5:0];
  assign imm_sext = {{16{ir_reg[15]}}, ir_reg[15:0]};

  logic [31:0] rf_rdata_a;
  logic [31:0] rf_rdata_b;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  assign rf_we    = (state_reg == ST_WB) && !reset;
  assign rf_waddr = (opcode == OP_RTYPE) ? rd : rt;
  assign rf_wdata = (opcode == OP_LW) ? mdr_reg : alu_out_reg;

  regfile_2r1w u_regfile (
    .clk     (clk),
    .reset   (reset),
    .raddr_a (rs),
    .rdata_a (rf_rdata_a),
    .raddr_b (rt),
    .rdata_b (rf_rdata_b),
    .we      (rf_we),
    .waddr   (rf_waddr),
    .wdata   (rf_wdata)
  );

  // ALU: R-type uses B and funct; everything else adds the sign-extended immediate.
  alu_op_t     alu_op;
  logic [31:0] alu_b;
  logic [31:0] alu_res;

  always_comb begin
    alu_op = ALU_ADD;
    alu_b  = imm_sext;
    if (opcode == OP_RTYPE) begin
      alu_op = funct_to_alu(funct);
      alu_b  = b_reg;
    end
    case (alu_op)
      ALU_SUB: alu_res = a_reg - alu_b;
      ALU_AND: alu_res = a_reg & alu_b;
      ALU_OR:  alu_res = a_reg | alu_b;
      ALU_SLT: alu_res = {31'd0, $signed(a_reg) < $signed(alu_b)};
      default: alu_res = a_reg + alu_b;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= ST_FETCH;
      pc_reg      <= RESET_PC;
      ir_reg      <= 32'd0;
      a_reg       <= 32'd0;
      b_reg       <= 32'd0;
      mdr_reg     <= 32'd0;
      alu_out_reg <= 32'd0;
      target_reg  <= 32'd0;
    end else begin
      case (state_reg)
        ST_FETCH: begin
          if (bus.mem_ready) begin
            ir_reg    <= bus.mem_rdata;
            pc_reg    <= pc_reg + 32'd4;
            state_reg <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          a_reg      <= rf_rdata_a;
          b_reg      <= rf_rdata_b;
          target_reg <= pc_reg + (imm_sext << 2);
          if (!is_legal(opcode, funct)) begin
            // pc already points past the faulting word; step back to it.
            pc_reg    <= pc_reg - 32'd4;
            state_reg <= ST_TRAP;
          end else if (opcode == OP_J) begin
            pc_reg    <= {pc_reg[31:28], ir_reg[25:0], 2'b00};
            state_reg <= ST_FETCH;
          end else begin
            state_reg <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          alu_out_reg <= alu_res;
          if (opcode == OP_BEQ) begin
            if (a_reg == b_reg) begin
              pc_reg <= target_reg;
            end
            state_reg <= ST_FETCH;
          end else if (opcode == OP_LW || opcode == OP_SW) begin
            if (alu_res[1:0] != 2'b00) begin
              pc_reg    <= pc_reg - 32'd4;
              state_reg <= ST_TRAP;
            end else begin
              state_reg <= ST_MEM;
            end
          end else begin
            state_reg <= ST_WB;
          end
        end
        ST_MEM: begin
          if (bus.mem_ready) begin
            if (opcode == OP_LW) begin
              mdr_reg   <= bus.mem_rdata;
              state_reg <= ST_WB;
            end else begin
              state_reg <= ST_FETCH;
            end
          end
        end
        ST_WB: begin
          state_reg <= ST_FETCH;
        end
        ST_TRAP: begin
          state_reg <= ST_TRAP;
        end
        default: begin
          state_reg <= ST_TRAP;
        end
      endcase
    end
  end

  logic [31:0] addr_full;

  assign addr_full     = (state_reg == ST_FETCH) ? pc_reg : alu_out_reg;
  assign bus.mem_addr  = addr_full[ADDR_W-1:0];
  assign bus.mem_wdata = b_reg;
  assign bus.mem_read  = (state_reg == ST_FETCH) ||
                         ((state_reg == ST_MEM) && (opcode == OP_LW));
  assign bus.mem_write = (state_reg == ST_MEM) && (opcode == OP_SW);
  assign trap          = (state_reg == ST_TRAP);
  assign pc            = pc_reg;

  always_comb begin
    retire = 1'b0;
    case (state_reg)
      ST_DECODE: retire = (opcode == OP_J);
      ST_EXEC:   retire = (opcode == OP_BEQ);
      ST_MEM:    retire = (opcode == OP_SW) && bus.mem_ready;
      ST_WB:     retire = 1'b1;
      default:   retire = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Directed bench: memory model with configurable stalls, scoreboards of
// expected retire cycles and expected memory writes, plus direct checks.
module tb_mips_multicycle_core;

  logic        clk = 1'b0;
  logic        reset;
  logic        retire;
  logic        trap;
  logic [31:0] pc;

  mips_multicycle_core_if #(.ADDR_W(32)) bus ();

  mips_multicycle_core #(
    .RESET_PC (32'h0000_0000),
    .ADDR_W   (32)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus),
    .retire (retire),
    .trap   (trap),
    .pc     (pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          stall_n = 0;
  bit          ready_always = 1'b0;
  int          wait_cnt = 0;
  int          writes_done = 0;
  int          write_seen = 0;
  int          saved_writes;
  bit          sb_on = 1'b0;
  logic        mon_req;
  logic [31:0] held_addr;
  logic [31:0] held_wdata;
  logic [31:0] mem [0:255];
  wr_t         exp_wr[$];
  int          exp_ret[$];
  wr_t         wr_e;

  assign bus.mem_rdata = mem[bus.mem_addr[9:2]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] r_type(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  always @(posedge clk) cyc <= reset ? 1 : cyc + 1;

  always @(posedge clk) begin
    #1;
    bus.mem_ready = ready_always || ((bus.mem_read || bus.mem_write) && (wait_cnt >= stall_n));
  end

  // Bus monitor and memory: completes requests, checks stability and scoreboards.
  always @(negedge clk) begin
    if (reset) begin
      wait_cnt = 0;
    end else begin
      mon_req = bus.mem_read || bus.mem_write;
      chk("rw_exclusive", {31'd0, bus.mem_read && bus.mem_write}, 32'd0);
      if (mon_req && wait_cnt > 0) begin
        chk("addr_stable", bus.mem_addr, held_addr);
        if (bus.mem_write) chk("wdata_stable", bus.mem_wdata, held_wdata);
      end
      held_addr  = bus.mem_addr;
      held_wdata = bus.mem_wdata;
      if (bus.mem_write) write_seen++;
      if (mon_req && bus.mem_ready) begin
        if (bus.mem_write) begin
          mem[bus.mem_addr[9:2]] = bus.mem_wdata;
          writes_done++;
          chk("write_expected", {31'd0, exp_wr.size() > 0}, 32'd1);
          if (exp_wr.size() > 0) begin
            wr_e = exp_wr.pop_front();
            chk("write_addr", bus.mem_addr, wr_e.addr);
            chk("write_data", bus.mem_wdata, wr_e.data);
            $display("write addr=%h data=%h cycle=%0d", bus.mem_addr, bus.mem_wdata, cyc);
          end
        end
        wait_cnt = 0;
      end else if (mon_req) begin
        wait_cnt++;
      end else begin
        wait_cnt = 0;
      end
      if (sb_on && retire) begin
        chk("retire_expected", {31'd0, exp_ret.size() > 0}, 32'd1);
        if (exp_ret.size() > 0) begin
          chk("retire_cycle", cyc, exp_ret.pop_front());
          $display("retire cycle=%0d pc=%h", cyc, pc);
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #3 reset = 1'b1;
    @(posedge clk); #3 reset = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    do @(negedge clk); while (cyc < n);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;

    // Dependent addi/add chain with mem_ready tied high, then a beq self-loop.
    clear_mem();
    mem[0] = i_type(6'h08, 5'd0, 5'd1, 16'd5);
    mem[1] = i_type(6'h08, 5'd0, 5'd2, 16'd7);
    mem[2] = r_type(5'd1, 5'd2, 5'd3, 6'h20);
    mem[3] = i_type(6'h2B, 5'd0, 5'd3, 16'h0080);
    mem[4] = i_type(6'h04, 5'd0, 5'd0, 16'hFFFF);
    ready_always = 1'b1; stall_n = 0;
    exp_ret = '{4, 8, 12, 16, 19, 22, 25};
    exp_wr.push_back('{32'h80, 32'd12});
    sb_on = 1'b1;
    do_reset();
    wait_cyc(1);
    chk("rst_mem_read", {31'd0, bus.mem_read}, 32'd1);
    chk("rst_mem_write", {31'd0, bus.mem_write}, 32'd0);
    chk("rst_retire", {31'd0, retire}, 32'd0);
    chk("rst_trap", {31'd0, trap}, 32'd0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_addr", bus.mem_addr, 32'h0);
    wait_cyc(13); chk("s1_pc_after_add", pc, 32'h0C);
    wait_cyc(20); chk("beq_pc_1", pc, 32'h10);
    wait_cyc(23); chk("beq_pc_2", pc, 32'h10);
    wait_cyc(26); chk("beq_pc_3", pc, 32'h10);
    sb_on = 1'b0;
    chk("s1_retire_left", exp_ret.size(), 32'd0);
    chk("s1_write_left", exp_wr.size(), 32'd0);

    // lw with three wait cycles per request; the loaded word then traps as code.
    clear_mem();
    mem[0] = i_type(6'h23, 5'd0, 5'd4, 16'd4);
    mem[1] = 32'hDEADBEEF;
    ready_always = 1'b0; stall_n = 3;
    exp_ret = '{11};
    sb_on = 1'b1;
    do_reset();
    wait_cyc(7);
    chk("lw_mem_read", {31'd0, bus.mem_read}, 32'd1);
    chk("lw_mem_addr", bus.mem_addr, 32'h4);
    wait_cyc(17);
    chk("lw_next_trap", {31'd0, trap}, 32'd1);
    chk("lw_next_trap_pc", pc, 32'h4);
    sb_on = 1'b0;
    chk("s2_retire_left", exp_ret.size(), 32'd0);

    // Load/store round trip, j, $0 discard, signed slt, sub/and/or, cleared regs.
    clear_mem();
    mem[0]  = i_type(6'h23, 5'd0, 5'd4, 16'h0084);
    mem[1]  = i_type(6'h2B, 5'd0, 5'd4, 16'h0088);
    mem[2]  = {6'h02, 26'h40};
    mem[33] = 32'hDEADBEEF;
    mem[64] = i_type(6'h08, 5'd0, 5'd0, 16'd9);
    mem[65] = r_type(5'd0, 5'd0, 5'd5, 6'h20);
    mem[66] = i_type(6'h2B, 5'd0, 5'd5, 16'h008C);
    mem[67] = i_type(6'h08, 5'd0, 5'd6, 16'hFFFF);
    mem[68] = i_type(6'h08, 5'd0, 5'd7, 16'd1);
    mem[69] = r_type(5'd6, 5'd7, 5'd8, 6'h2A);
    mem[70] = i_type(6'h2B, 5'd0, 5'd8, 16'h0090);
    mem[71] = r_type(5'd7, 5'd6, 5'd9, 6'h22);
    mem[72] = i_type(6'h2B, 5'd0, 5'd9, 16'h0094);
    mem[73] = i_type(6'h2B, 5'd0, 5'd3, 16'h0098);
    mem[74] = r_type(5'd6, 5'd7, 5'd10, 6'h25);
    mem[75] = r_type(5'd6, 5'd7, 5'd11, 6'h24);
    mem[76] = i_type(6'h2B, 5'd0, 5'd10, 16'h009C);
    mem[77] = i_type(6'h2B, 5'd0, 5'd11, 16'h00A0);
    mem[78] = i_type(6'h04, 5'd7, 5'd6, 16'd5);
    mem[79] = {6'h02, 26'h4F};
    stall_n = 0;
    exp_ret = '{5, 9, 11, 15, 19, 23, 27, 31, 35, 39, 43, 47, 51, 55, 59, 63, 67, 70, 72};
    exp_wr.push_back('{32'h88, 32'hDEADBEEF});
    exp_wr.push_back('{32'h8C, 32'h0});
    exp_wr.push_back('{32'h90, 32'h1});
    exp_wr.push_back('{32'h94, 32'h2});
    exp_wr.push_back('{32'h98, 32'h0});
    exp_wr.push_back('{32'h9C, 32'hFFFFFFFF});
    exp_wr.push_back('{32'hA0, 32'h1});
    sb_on = 1'b1;
    do_reset();
    wait_cyc(12); chk("j_pc", pc, 32'h100);
    wait_cyc(73); chk("j_loop_pc", pc, 32'h13C);
    sb_on = 1'b0;
    chk("s3_retire_left", exp_ret.size(), 32'd0);
    chk("s3_write_left", exp_wr.size(), 32'd0);

    // Misaligned sw traps without ever writing; only reset recovers.
    clear_mem();
    mem[0] = i_type(6'h08, 5'd0, 5'd1, 16'd6);
    mem[1] = i_type(6'h2B, 5'd1, 5'd2, 16'd0);
    exp_ret = '{4};
    sb_on = 1'b1;
    do_reset();
    write_seen = 0;
    wait_cyc(8);
    chk("sw_trap", {31'd0, trap}, 32'd1);
    chk("sw_trap_pc", pc, 32'h4);
    wait_cyc(30);
    chk("sw_trap_hold", {31'd0, trap}, 32'd1);
    chk("sw_trap_pc_hold", pc, 32'h4);
    chk("sw_trap_no_read", {31'd0, bus.mem_read}, 32'd0);
    chk("sw_trap_no_write", write_seen, 32'd0);
    sb_on = 1'b0;
    chk("s4_retire_left", exp_ret.size(), 32'd0);

    // Opcode 0x3F, then an R-type with unsupported funct 0x21.
    clear_mem();
    mem[0] = 32'hFC000000;
    sb_on = 1'b1;
    do_reset();
    wait_cyc(1);
    chk("trap_recover_trap", {31'd0, trap}, 32'd0);
    chk("trap_recover_read", {31'd0, bus.mem_read}, 32'd1);
    wait_cyc(3);
    chk("op3f_trap", {31'd0, trap}, 32'd1);
    chk("op3f_pc", pc, 32'h0);
    wait_cyc(20);
    chk("op3f_trap_hold", {31'd0, trap}, 32'd1);
    mem[0] = r_type(5'd1, 5'd2, 5'd3, 6'h21);
    do_reset();
    wait_cyc(3);
    chk("funct_trap", {31'd0, trap}, 32'd1);
    chk("funct_trap_pc", pc, 32'h0);
    sb_on = 1'b0;

    // Reset while a sw is stalled in MEM.
    clear_mem();
    mem[0] = i_type(6'h08, 5'd0, 5'd1, 16'h0055);
    mem[1] = i_type(6'h2B, 5'd0, 5'd1, 16'h0080);
    stall_n = 5;
    exp_ret = '{9};
    sb_on = 1'b1;
    do_reset();
    saved_writes = writes_done;
    wait_cyc(20);
    chk("stall_sw_write", {31'd0, bus.mem_write}, 32'd1);
    chk("stall_sw_addr", bus.mem_addr, 32'h80);
    sb_on = 1'b0;
    chk("s6_retire_left", exp_ret.size(), 32'd0);
    do_reset();
    wait_cyc(1);
    chk("abort_mem_write", {31'd0, bus.mem_write}, 32'd0);
    chk("abort_mem_read", {31'd0, bus.mem_read}, 32'd1);
    chk("abort_pc", pc, 32'h0);
    chk("abort_no_write", writes_done - saved_writes, 32'd0);
    wait_cyc(4);
    chk("abort_no_write_later", writes_done - saved_writes, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
